// File: rtl/freq_meas_sched_if.sv
// Shared edge-counter control and result handshake between the scheduler
// (master) and the counter/consumer side (slave).
interface freq_meas_sched_if #(
    parameter int NCH = 4,
    parameter int CW  = 32
) ();
    logic [$clog2(NCH)-1:0] ch_sel;
    logic                   cnt_clear;
    logic                   cnt_enable;
    logic [CW-1:0]          cnt_value;
    logic                   res_valid;
    logic [$clog2(NCH)-1:0] res_ch;
    logic [CW-1:0]          res_count;
    logic                   res_ready;

    modport master (
        output ch_sel, cnt_clear, cnt_enable, res_valid, res_ch, res_count,
        input  cnt_value, res_ready
    );

    modport slave (
        input  ch_sel, cnt_clear, cnt_enable, res_valid, res_ch, res_count,
        output cnt_value, res_ready
    );
endinterface

// File: rtl/freq_meas_sched.sv
// Round-robin frequency measurement scheduler: steers a shared edge counter
// across enabled channels, gates it for a fixed window and hands out results.
module freq_meas_sched #(
    parameter int NCH      = 4,
    parameter int CW       = 32,
    parameter int SYNC_LAT = 2
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    input  logic [CW-1:0]  cfg_gate_cycles,
    input  logic [NCH-1:0] cfg_ch_enable,
    input  logic           cfg_continuous,
    input  logic           start,
    input  logic           stop,
    output logic           busy,
    freq_meas_sched_if.master bus
);
    localparam int CHW = $clog2(NCH);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SELECT  = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_GATE    = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_CAPTURE = 3'd5;
    localparam logic [2:0] S_OUTPUT  = 3'd6;

    logic [2:0]     r_state;
    logic [CW-1:0]  r_timer;
    logic [CW-1:0]  r_gate;
    logic [NCH-1:0] r_en;
    logic           r_cont;
    logic [NCH-1:0] r_pending;
    logic [CHW-1:0] r_ch_sel;
    logic           r_cnt_clear;
    logic           r_cnt_enable;
    logic           r_res_valid;
    logic [CHW-1:0] r_res_ch;
    logic [CW-1:0]  r_res_count;
    logic           r_busy;

    logic [CW-1:0]  w_gate_last;
    logic [CW-1:0]  w_sync_last;
    logic [NCH-1:0] w_onehot;
    logic [NCH-1:0] w_remain;
    logic [CHW-1:0] w_next_ptr;

    // First set bit of mask at or after 'from', wrapping around NCH.
    function automatic logic [CHW-1:0] f_pick(input logic [NCH-1:0] mask,
                                              input logic [CHW-1:0] from);
        logic [CHW-1:0] res;
        logic           found;
        int             idx;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            idx = (int'(from) + i) % NCH;
            if (!found && mask[idx]) begin
                res   = CHW'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // A gate of zero still opens the counter for one cycle.
    assign w_gate_last = (r_gate == '0) ? '0 : r_gate - CW'(1);
    assign w_sync_last = CW'(SYNC_LAT - 1);
    assign w_onehot    = NCH'(1) << r_res_ch;
    assign w_remain    = r_pending & ~w_onehot;
    assign w_next_ptr  = (r_res_ch == CHW'(NCH - 1)) ? '0 : r_res_ch + CHW'(1);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_gate       <= '0;
            r_en         <= '0;
            r_cont       <= 1'b0;
            r_pending    <= '0;
            r_ch_sel     <= '0;
            r_cnt_clear  <= 1'b0;
            r_cnt_enable <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_ch     <= '0;
            r_res_count  <= '0;
            r_busy       <= 1'b0;
        end else if (stop) begin
            r_state      <= S_IDLE;
            r_cnt_clear  <= 1'b0;
            r_cnt_enable <= 1'b0;
            r_res_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (cfg_ch_enable != '0)) begin
                        r_gate    <= cfg_gate_cycles;
                        r_en      <= cfg_ch_enable;
                        r_cont    <= cfg_continuous;
                        r_pending <= cfg_ch_enable;
                        r_ch_sel  <= f_pick(cfg_ch_enable, '0);
                        r_state   <= S_SELECT;
                        r_busy    <= 1'b1;
                    end
                end
                S_SELECT: begin
                    r_state     <= S_SETTLE;
                    r_cnt_clear <= 1'b1;
                    r_timer     <= w_sync_last;
                end
                S_SETTLE: begin
                    if (r_timer == '0) begin
                        r_state      <= S_GATE;
                        r_cnt_clear  <= 1'b0;
                        r_cnt_enable <= 1'b1;
                        r_timer      <= w_gate_last;
                    end else begin
                        r_timer <= r_timer - CW'(1);
                    end
                end
                S_GATE: begin
                    if (r_timer == '0) begin
                        r_state <= S_DRAIN;
                        r_timer <= w_sync_last;
                    end else begin
                        r_timer <= r_timer - CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_timer == '0) begin
                        r_state      <= S_CAPTURE;
                        r_cnt_enable <= 1'b0;
                    end else begin
                        r_timer <= r_timer - CW'(1);
                    end
                end
                S_CAPTURE: begin
                    r_res_count <= bus.cnt_value;
                    r_res_ch    <= r_ch_sel;
                    r_res_valid <= 1'b1;
                    r_state     <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    // Channel selection for the next measurement is resolved here so
                    // ch_sel is already stable while SELECT is presented.
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        if (w_remain != '0) begin
                            r_pending <= w_remain;
                            r_ch_sel  <= f_pick(w_remain, w_next_ptr);
                            r_state   <= S_SELECT;
                        end else if (r_cont) begin
                            r_pending <= r_en;
                            r_ch_sel  <= f_pick(r_en, '0);
                            r_state   <= S_SELECT;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ch_sel     = r_ch_sel;
    assign bus.cnt_clear  = r_cnt_clear;
    assign bus.cnt_enable = r_cnt_enable;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_ch     = r_res_ch;
    assign bus.res_count  = r_res_count;
    assign busy           = r_busy;
endmodule

// File: tb/tb_freq_meas_sched.sv
// Bench for freq_meas_sched: timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_freq_meas_sched;
    localparam int NCH = 4;
    localparam int CW  = 32;
    localparam int SL  = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [CW-1:0]  gate = '0;
    logic [NCH-1:0] en = '0;
    logic           cont = 1'b0;
    logic           start = 1'b0;
    logic           stop = 1'b0;
    logic           ready = 1'b1;
    logic           busy;

    freq_meas_sched_if #(.NCH(NCH), .CW(CW)) bus ();

    freq_meas_sched #(.NCH(NCH), .CW(CW), .SYNC_LAT(SL)) dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .cfg_gate_cycles (gate),
        .cfg_ch_enable   (en),
        .cfg_continuous  (cont),
        .start           (start),
        .stop            (stop),
        .busy            (busy),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    // Environment: shared edge counter fed by a per-channel input period.
    int unsigned cyc = 0;
    int          per [NCH] = '{4, 4, 4, 4};
    logic [CW-1:0] cnt = '0;
    assign bus.cnt_value = cnt;
    assign bus.res_ready = ready;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.cnt_clear === 1'b1)
            cnt <= '0;
        else if (bus.cnt_enable === 1'b1 && (cyc % per[bus.ch_sel]) == 0)
            cnt <= cnt + 1;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference model: each measurement is a timeline measured from its SELECT cycle.
    bit             m_known = 0;
    bit             m_act = 0;
    bit             m_post_rst = 0;
    logic [NCH-1:0] m_en = '0;
    logic [NCH-1:0] m_left = '0;
    logic [CW-1:0]  m_gate = '0;
    bit             m_cont = 0;
    int             m_ch = 0;
    longint         m_t0 = 0;
    longint         m_exp = 0;

    int     en_cycles = 0;
    int     res_ch_q[$];
    longint res_cnt_q[$];

    function automatic int lowest_from(input logic [NCH-1:0] m, input int from);
        for (int i = 0; i < NCH; i++)
            if (m[(from + i) % NCH]) return (from + i) % NCH;
        return 0;
    endfunction

    function automatic int gate_eff(input logic [CW-1:0] g);
        return (g == 0) ? 1 : int'(g);
    endfunction

    function automatic longint ticks(input longint t0, input int ch, input int ge);
        longint n = 0;
        for (longint c = t0 + SL + 1; c <= t0 + 2 * SL + ge; c++)
            if ((c % per[ch]) == 0) n++;
        return n;
    endfunction

    task automatic begin_meas(input int ch);
        m_ch  = ch;
        m_t0  = longint'(cyc) + 1;
        m_exp = ticks(m_t0, ch, gate_eff(m_gate));
    endtask

    always @(negedge clk) begin : compare
        longint off;
        int     ge;
        bit     e_clr, e_en, e_val;
        ge    = gate_eff(m_gate);
        off   = longint'(cyc) - m_t0;
        e_clr = m_act && off >= 1 && off <= SL;
        e_en  = m_act && off >= SL + 1 && off <= 2 * SL + ge;
        e_val = m_act && off >= 2 * SL + ge + 2;
        if (m_known) begin
            check("busy", busy, m_act);
            check("cnt_clear", bus.cnt_clear, e_clr);
            check("cnt_enable", bus.cnt_enable, e_en);
            check("res_valid", bus.res_valid, e_val);
            if (m_act) check("ch_sel", bus.ch_sel, m_ch);
            if (e_val) begin
                check("res_ch", bus.res_ch, m_ch);
                check("res_count", bus.res_count, m_exp);
            end
            if (m_post_rst) begin
                check("rst_ch_sel", bus.ch_sel, 0);
                check("rst_res_ch", bus.res_ch, 0);
                check("rst_res_count", bus.res_count, 0);
            end
            if (bus.cnt_enable === 1'b1) en_cycles++;
            if (bus.res_valid === 1'b1 && ready) begin
                res_ch_q.push_back(int'(bus.res_ch));
                res_cnt_q.push_back(longint'(bus.res_count));
            end
        end
        if (rst) begin
            m_known = 1; m_act = 0; m_post_rst = 1;
            m_en = '0; m_gate = '0; m_cont = 0;
        end else if (!m_known) begin
            m_act = 0;
        end else if (stop) begin
            m_act = 0;
        end else if (!m_act) begin
            if (start && en != 0) begin
                m_en = en; m_gate = gate; m_cont = cont;
                m_left = en; m_act = 1; m_post_rst = 0;
                begin_meas(lowest_from(en, 0));
            end
        end else if (e_val && ready) begin
            m_left[m_ch] = 1'b0;
            if (m_left != 0) begin
                begin_meas(lowest_from(m_left, (m_ch + 1) % NCH));
            end else if (m_cont) begin
                m_left = m_en;
                begin_meas(lowest_from(m_en, 0));
            end else begin
                m_act = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Configuration is scrambled right after the start pulse; it must not matter.
    task automatic pulse_start(input logic [CW-1:0] g, input logic [NCH-1:0] e, input logic c);
        gate = g; en = e; cont = c; start = 1'b1;
        tick();
        start = 1'b0;
        gate = CW'($urandom_range(0, 300));
        en = NCH'($urandom);
        cont = 1'($urandom);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            tick();
            k++;
        end
        check(name, busy, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n0, e0, k, vcount;
        logic [CW-1:0] held;
        bit stable;
        repeat (3) tick();
        check("reset busy", busy, 0);
        check("reset res_valid", bus.res_valid, 0);
        check("reset cnt_enable", bus.cnt_enable, 0);
        check("reset cnt_clear", bus.cnt_clear, 0);
        check("reset ch_sel", bus.ch_sel, 0);
        check("reset res_count", bus.res_count, 0);
        rst = 1'b0;
        tick();

        // Two-channel single sweep, counter +1 every 4 cycles.
        n0 = res_ch_q.size(); e0 = en_cycles;
        pulse_start(100, 4'b0101, 1'b0);
        wait_idle(400, "sweep0101 idle");
        check("sweep0101 results", res_ch_q.size() - n0, 2);
        if (res_ch_q.size() >= n0 + 2) begin
            check("sweep0101 first ch", res_ch_q[n0], 0);
            check("sweep0101 second ch", res_ch_q[n0 + 1], 2);
            check_range("sweep0101 count0", res_cnt_q[n0], 24, 26);
            check_range("sweep0101 count2", res_cnt_q[n0 + 1], 24, 26);
        end
        check("sweep0101 enable cycles", en_cycles - e0, 2 * (100 + SL));

        // Zero gate behaves as a one-cycle gate.
        n0 = res_ch_q.size(); e0 = en_cycles;
        pulse_start(0, 4'b0001, 1'b0);
        wait_idle(50, "gate0 idle");
        check("gate0 enable cycles", en_cycles - e0, 1 + SL);
        check("gate0 results", res_ch_q.size() - n0, 1);
        if (res_ch_q.size() > n0) check("gate0 ch", res_ch_q[n0], 0);

        // Back-pressure: result held stable while res_ready is low.
        ready = 1'b0;
        pulse_start(5, 4'b0010, 1'b0);
        k = 0;
        while (bus.res_valid !== 1'b1 && k < 100) begin tick(); k++; end
        check("hold valid seen", bus.res_valid, 1);
        held = bus.res_count; stable = 1;
        repeat (50) begin
            tick();
            if (bus.res_valid !== 1'b1 || bus.res_count !== held || bus.cnt_clear !== 1'b0) stable = 0;
        end
        check("hold stable 50 cycles", stable, 1);
        ready = 1'b1;
        tick();
        check("hold released valid", bus.res_valid, 0);
        wait_idle(50, "hold idle");

        // Continuous on channel 3, then stop during GATE.
        n0 = res_ch_q.size();
        pulse_start(20, 4'b1000, 1'b1);
        k = 0;
        while (res_ch_q.size() < n0 + 3 && k < 500) begin tick(); k++; end
        check("cont results", res_ch_q.size() >= n0 + 3, 1);
        for (int i = n0; i < res_ch_q.size(); i++) check("cont ch", res_ch_q[i], 3);
        k = 0;
        while (bus.cnt_clear !== 1'b1 && k < 100) begin tick(); k++; end
        while (bus.cnt_enable !== 1'b1 && k < 200) begin tick(); k++; end
        check("cont gate reached", bus.cnt_enable, 1);
        repeat (3) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop busy", busy, 0);
        check("stop cnt_enable", bus.cnt_enable, 0);
        n0 = res_ch_q.size(); vcount = 0;
        repeat (40) begin tick(); if (bus.res_valid === 1'b1) vcount++; end
        check("stop no valid", vcount, 0);
        check("stop no results", res_ch_q.size() - n0, 0);

        // Ignored starts: empty enable, and start while busy.
        pulse_start(10, 4'b0000, 1'b0);
        check("empty start busy", busy, 0);
        n0 = res_ch_q.size();
        pulse_start(30, 4'b0100, 1'b0);
        repeat (5) tick();
        pulse_start(30, 4'b0011, 1'b0);
        wait_idle(200, "busy start idle");
        check("busy start results", res_ch_q.size() - n0, 1);
        if (res_ch_q.size() > n0) check("busy start ch", res_ch_q[n0], 2);

        // Reset during DRAIN abandons the measurement.
        n0 = res_ch_q.size();
        pulse_start(10, 4'b0001, 1'b0);
        k = 0;
        while (bus.cnt_enable !== 1'b1 && k < 50) begin tick(); k++; end
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("drain rst busy", busy, 0);
        check("drain rst cnt_enable", bus.cnt_enable, 0);
        check("drain rst res_count", bus.res_count, 0);
        check("drain rst ch_sel", bus.ch_sel, 0);
        repeat (20) tick();
        check("drain rst results", res_ch_q.size() - n0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 8000; i++) begin
            if (busy === 1'b0 && $urandom_range(0, 30) == 0)
                for (int c = 0; c < NCH; c++) per[c] = $urandom_range(2, 7);
            gate  = CW'($urandom_range(0, 15));
            en    = NCH'($urandom);
            cont  = ($urandom_range(0, 3) == 0);
            start = ($urandom_range(0, 99) < 8);
            stop  = ($urandom_range(0, 299) == 0);
            rst   = ($urandom_range(0, 1499) == 0);
            ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        start = 1'b0; stop = 1'b0; rst = 1'b0; ready = 1'b1;
        repeat (5) tick();
        check_range("random results seen", res_ch_q.size(), 20, 1000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/freq_meas_sched.md
FREQ_MEAS_SCHED -- requirements
Module: freq_meas_sched

Interface
REQ-001 SHALL have parameter NCH, default 4, number of measured channels (2..8).
REQ-002 SHALL have parameter CW, default 32, width of the gate counter and the result.
REQ-003 SHALL have parameter SYNC_LAT, default 2, edge-counter synchronizer latency in cycles (1..4).
REQ-004 SHALL have port wb_clk_i  input  1  the single block clock.
REQ-005 SHALL have port wb_rst_i  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port cfg_gate_cycles  input  CW  gate window length in wb_clk_i cycles.
REQ-007 SHALL have port cfg_ch_enable  input  NCH  channels included in a sweep.
REQ-008 SHALL have port cfg_continuous  input  1  1 = repeat sweeps until stop.
REQ-009 SHALL have port start  input  1  single-cycle pulse that begins a sweep.
REQ-010 SHALL have port stop  input  1  single-cycle abort pulse.
REQ-011 SHALL have port ch_sel  output  clog2(NCH)  select for the shared input mux.
REQ-012 SHALL have port cnt_clear  output  1  clears the shared edge counter.
REQ-013 SHALL have port cnt_enable  output  1  gates the shared edge counter.
REQ-014 SHALL have port cnt_value  input  CW  shared edge counter value.
REQ-015 SHALL have port res_valid, res_ch, res_count  output  1/clog2(NCH)/CW  result handshake.
REQ-016 SHALL have port res_ready  input  1  result consumer ready.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement states IDLE, SELECT, SETTLE, GATE, DRAIN, CAPTURE, OUTPUT.
REQ-019 In IDLE, start with cfg_ch_enable!=0 SHALL latch cfg_gate_cycles, cfg_ch_enable and cfg_continuous, then go to SELECT; start with cfg_ch_enable==0 SHALL be ignored.
REQ-020 Changes to the cfg_* inputs while busy SHALL have no effect until the next start.
REQ-021 SELECT SHALL choose the lowest enabled channel index >= the round-robin pointer (wrapping), drive it onto ch_sel and go to SETTLE in 1 cycle.
REQ-022 SETTLE SHALL last SYNC_LAT cycles with cnt_clear=1 and cnt_enable=0.
REQ-023 GATE SHALL last exactly max(latched gate_cycles,1) cycles with cnt_enable=1; a gate value of 0 SHALL be treated as 1.
REQ-024 DRAIN SHALL last SYNC_LAT cycles with cnt_enable=1, covering in-flight edges, then go to CAPTURE.
REQ-025 CAPTURE SHALL register cnt_value into res_count and ch_sel into res_ch, with cnt_enable=0, and go to OUTPUT next cycle.
REQ-026 OUTPUT SHALL hold res_valid=1 with stable res_ch/res_count until a cycle with res_ready=1; the transfer SHALL occur in that cycle.
REQ-027 After a transfer, the pointer SHALL advance to res_ch+1 mod NCH; if enabled channels remain in the sweep, go to SELECT.
REQ-028 At sweep end, with cfg_continuous=1 the next sweep SHALL begin at SELECT with the pointer at 0; otherwise go to IDLE.
REQ-029 ch_sel SHALL stay constant from SELECT through OUTPUT of one measurement.
REQ-030 stop SHALL force IDLE on the next edge from any state, dropping any pending result (res_valid=0); stop takes priority over start in the same cycle.
REQ-031 start while busy SHALL be ignored.
REQ-032 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-033 On wb_rst_i=1 at a clock edge, state=IDLE, pointer=0, ch_sel=0, cnt_clear=0, cnt_enable=0, res_valid=0, res_ch=0, res_count=0, busy=0, latched cfg=0.
REQ-034 Reset mid-measurement SHALL abandon the measurement with no res_valid pulse.

Verification
REQ-035 enable=4'b0101, gate=100, single, counter model +1 per 4 cycles, res_ready=1 -> results ch0 then ch2, each count 25+/-1, busy falls afterward, cnt_enable high exactly 100+SYNC_LAT cycles per channel.
REQ-036 gate=0, enable=4'b0001 -> cnt_enable high 1+SYNC_LAT cycles, one result for ch0.
REQ-037 res_ready held 0 for 50 cycles in OUTPUT -> res_valid/res_count stable for all 50; next SELECT only after res_ready=1.
REQ-038 continuous=1, enable=4'b1000 -> repeated ch3 results; stop in GATE -> IDLE next cycle, no further res_valid.
REQ-039 start with enable=0, and start while busy -> no state change, no extra result.
REQ-040 wb_rst_i asserted in DRAIN -> all outputs at reset values next cycle, no result emitted.
